mem_arbiter: RTL and testbench

Shares one memory bus between the CPU core's instruction-fetch port and data port. It replaces the separate imem/dmem connections with a single-master bus, granting one requester at a time. Arbitration is fixed-priority, data before instruction, with optional starvation protection for fetch. It sits between `riscv_cpu` and the unified SRAM/interconnect in the SoC top.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_pick.sv | 22 ++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Starvation protection is enabled by defining MEM_ARB_STARVE_EN.
package mem_arb_pkg;

  // One-hot encoding so a corrupted state is detectable and can recover to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GNT_I = 3'b010,
    GNT_D = 3'b100
  } arb_state_t;

  localparam int STARVE_CNT_W         = 4;
  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority arbitration decision: data before fetch unless fetch is starving.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  logic       starve,
  output arb_state_t next_state
);

  always_comb begin
    next_state = IDLE;
    if (req_d && !starve) begin
      next_state = GNT_D;
    end else if (req_i) begin
      next_state = GNT_I;
    end else if (req_d) begin
      next_state = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-master bus arbiter between the CPU fetch and data ports.
// Define MEM_ARB_STARVE_EN to add the d_streak counter that guarantees fetch progress.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] imem_addr,
  input  logic            imem_req,
  output logic [XLEN-1:0] imem_rdata,
  output logic            imem_ready,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [3:0]      dmem_we,
  input  logic            dmem_req,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_ready,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_we,
  output logic            bus_req,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ready,
  output logic            grant_i,
  output logic            grant_d
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be within 1..15");
  end

  arb_state_t state;
  arb_state_t next_state;
  arb_state_t pick_state;
  logic       starve;
  logic       pick_en;

  mem_arb_pick u_pick (
    .req_i      (imem_req),
    .req_d      (dmem_req),
    .starve     (starve),
    .next_state (pick_state)
  );

  // A new owner is chosen from IDLE or when the current transfer completes.
  assign pick_en = (state == IDLE) ||
                   (((state == GNT_I) || (state == GNT_D)) && bus_ready);

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:         next_state = pick_state;
      GNT_I, GNT_D: next_state = bus_ready ? pick_state : state;
      default:      next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

`ifdef MEM_ARB_STARVE_EN
  logic [STARVE_CNT_W-1:0] d_streak;

  // Counts data grants handed out while a fetch waits; saturates rather than wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_streak <= '0;
    end else if (!imem_req) begin
      d_streak <= '0;
    end else if (pick_en && (next_state == GNT_I)) begin
      d_streak <= '0;
    end else if (pick_en && (next_state == GNT_D) && (d_streak != '1)) begin
      d_streak <= d_streak + 1'b1;
    end
  end

  assign starve = (d_streak >= STARVE_CNT_W'(STARVE_LIMIT));
`else
  assign starve = 1'b0;
`endif

  // Bus outputs decode straight from the state register so reset drops them at once.
  always_comb begin
    bus_req    = 1'b0;
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_we     = '0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      GNT_I: begin
        bus_req    = 1'b1;
        bus_addr   = imem_addr;
        imem_ready = bus_ready;
        grant_i    = 1'b1;
      end
      GNT_D: begin
        bus_req    = 1'b1;
        bus_addr   = dmem_addr;
        bus_wdata  = dmem_wdata;
        bus_we     = dmem_we;
        dmem_ready = bus_ready;
        grant_d    = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_rdata = bus_rdata;
  assign dmem_rdata = bus_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level owner/streak model.
module tb_mem_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_ready;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_we;
  logic            dmem_req;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ready;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_we;
  logic            bus_req;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_ready;
  logic            grant_i;
  logic            grant_d;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data) and D grants in a row.
  int m_owner = 0;
  int m_streak = 0;

  mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_req   (dmem_req),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_req    (bus_req),
    .bus_rdata  (bus_rdata),
    .bus_ready  (bus_ready),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [136:0] model_out();
    logic [31:0] a, w;
    logic [3:0]  we;
    a  = (m_owner == 1) ? imem_addr : (m_owner == 2) ? dmem_addr : 32'h0;
    w  = (m_owner == 2) ? dmem_wdata : 32'h0;
    we = (m_owner == 2) ? dmem_we : 4'h0;
    return {m_owner != 0, a, w, we, (m_owner == 1) && bus_ready, (m_owner == 2) && bus_ready,
            m_owner == 1, m_owner == 2, bus_rdata, bus_rdata};
  endfunction

  task automatic model_tick();
    bit served_by_pick;
    int nxt;
    served_by_pick = (m_owner == 0) || bus_ready;
    nxt = m_owner;
    if (served_by_pick) begin
      if (dmem_req && !(STARVE_ON && m_streak >= LIMIT)) nxt = 2;
      else if (imem_req)                                 nxt = 1;
      else if (dmem_req)                                 nxt = 2;
      else                                               nxt = 0;
    end
    if (!imem_req)                             m_streak = 0;
    else if (served_by_pick && nxt == 1)       m_streak = 0;
    else if (served_by_pick && nxt == 2 && m_streak < 15) m_streak++;
    m_owner = nxt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req = 0; dmem_req = 0; bus_ready = 0;
    imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_we = 0; bus_rdata = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_owner = 0;
    m_streak = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req = 1; dmem_req = 1; bus_ready = 1;
    imem_addr = $urandom; dmem_addr = $urandom; dmem_wdata = $urandom; dmem_we = 4'hF;
    bus_rdata = $urandom;
    step(); step();
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    n_cmp++; if (bus_addr !== 32'h0) begin n_bad++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
    n_cmp++; if (bus_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_bus_wdata: got %h want 0", bus_wdata); end
    n_cmp++; if (bus_we !== 4'h0) begin n_bad++; $display("FAIL reset_bus_we: got %h want 0", bus_we); end
    n_cmp++; if ({imem_ready, dmem_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", {imem_ready, dmem_ready}); end
    n_cmp++; if ({grant_i, grant_d} !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", {grant_i, grant_d}); end
    do_reset();
  endtask

  task automatic test_single_fetch();
    do_reset();
    imem_req = 1; imem_addr = 32'h100; bus_rdata = 32'h13; bus_ready = 1;
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL fetch_cycle0_bus_req: got %b want 0", bus_req); end
    step(); #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL fetch_bus_req: got %b want 1", bus_req); end
    n_cmp++; if (bus_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_bus_addr: got %h want 100", bus_addr); end
    n_cmp++; if (bus_we !== 4'h0) begin n_bad++; $display("FAIL fetch_bus_we: got %h want 0", bus_we); end
    n_cmp++; if (imem_ready !== 1'b1 || dmem_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_ready: got i=%b d=%b want i=1 d=0", imem_ready, dmem_ready); end
    n_cmp++; if (imem_rdata !== 32'h13) begin n_bad++; $display("FAIL fetch_rdata: got %h want 13", imem_rdata); end
    imem_req = 0;
    step(); #1;
    n_cmp++; if ({bus_req, imem_ready} !== 2'b00) begin n_bad++; $display("FAIL fetch_release: got %b want 00", {bus_req, imem_ready}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    imem_req = 1; imem_addr = 32'h104;
    dmem_req = 1; dmem_addr = 32'h200; dmem_we = 4'hF; dmem_wdata = 32'hDEADBEEF;
    bus_ready = 1; bus_rdata = 32'h55AA_1234;
    step(); #1;
    n_cmp++; if ({grant_d, grant_i} !== 2'b10) begin n_bad++; $display("FAIL simul_first_grant: got d/i=%b want 10", {grant_d, grant_i}); end
    n_cmp++; if (bus_we !== 4'hF || bus_wdata !== 32'hDEADBEEF || bus_addr !== 32'h200) begin n_bad++; $display("FAIL simul_d_bus: got we=%h wd=%h a=%h want F DEADBEEF 200", bus_we, bus_wdata, bus_addr); end
    n_cmp++; if ({dmem_ready, imem_ready} !== 2'b10) begin n_bad++; $display("FAIL simul_d_ready: got d/i=%b want 10", {dmem_ready, imem_ready}); end
    dmem_req = 0;
    step(); #1;
    n_cmp++; if ({grant_d, grant_i} !== 2'b01) begin n_bad++; $display("FAIL simul_second_grant: got d/i=%b want 01", {grant_d, grant_i}); end
    n_cmp++; if (bus_we !== 4'h0 || bus_wdata !== 32'h0 || bus_addr !== 32'h104) begin n_bad++; $display("FAIL simul_i_bus: got we=%h wd=%h a=%h want 0 0 104", bus_we, bus_wdata, bus_addr); end
    n_cmp++; if ({dmem_ready, imem_ready} !== 2'b01) begin n_bad++; $display("FAIL simul_i_ready: got d/i=%b want 01", {dmem_ready, imem_ready}); end
    imem_req = 0;
    step();
  endtask

  task automatic test_wait_states();
    int d_pulses;
    d_pulses = 0;
    do_reset();
    imem_req = 1; imem_addr = 32'h108;
    dmem_req = 1; dmem_addr = 32'h300; dmem_we = 4'h3; dmem_wdata = $urandom;
    bus_ready = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      #1;
      d_pulses += int'(dmem_ready);
      n_cmp++; if (bus_addr !== 32'h300 || bus_we !== 4'h3 || grant_d !== 1'b1) begin n_bad++; $display("FAIL wait_hold[%0d]: got a=%h we=%h gd=%b want 300 3 1", k, bus_addr, bus_we, grant_d); end
      n_cmp++; if ({imem_ready, dmem_ready} !== 2'b00) begin n_bad++; $display("FAIL wait_ready[%0d]: got %b want 00", k, {imem_ready, dmem_ready}); end
      step();
    end
    bus_ready = 1;
    #1;
    d_pulses += int'(dmem_ready);
    n_cmp++; if (imem_ready !== 1'b0) begin n_bad++; $display("FAIL wait_iready_in_d: got %b want 0", imem_ready); end
    dmem_req = 0;
    step(); #1;
    d_pulses += int'(dmem_ready);
    n_cmp++; if (imem_ready !== 1'b1 || bus_addr !== 32'h108) begin n_bad++; $display("FAIL wait_then_fetch: got ir=%b a=%h want 1 108", imem_ready, bus_addr); end
    imem_req = 0;
    step(); #1;
    d_pulses += int'(dmem_ready);
    n_cmp++; if (d_pulses !== 1) begin n_bad++; $display("FAIL wait_dready_pulses: got %0d want 1", d_pulses); end
  endtask

  task automatic test_starvation();
    string got, want;
    do_reset();
    imem_req = 1; imem_addr = 32'h10C;
    dmem_req = 1; dmem_addr = 32'h400; dmem_we = 4'h0;
    bus_ready = 1;
    step();
    for (int k = 0; k < 10; k++) begin
      #1;
      got  = grant_d ? "D" : (grant_i ? "I" : "-");
      want = (STARVE_ON && (k % (LIMIT + 1) == LIMIT)) ? "I" : "D";
      n_cmp++; if (got != want) begin n_bad++; $display("FAIL starve_grant[%0d]: got %s want %s", k, got, want); end
      step();
    end
    imem_req = 0; dmem_req = 0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dmem_req = 1; dmem_addr = 32'h500; dmem_we = 4'h1; bus_ready = 0;
    step(); #1;
    n_cmp++; if (grant_d !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_grant: got %b want 1", grant_d); end
    bus_ready = 1;
    rst_n = 0;
    #1;
    n_cmp++; if ({bus_req, imem_ready, dmem_ready, grant_d} !== 4'b0000) begin n_bad++; $display("FAIL rstmid_async_drop: got %b want 0000", {bus_req, imem_ready, dmem_ready, grant_d}); end
    dmem_req = 0; bus_ready = 0;
    @(negedge clk);
    rst_n = 1;
    m_owner = 0; m_streak = 0;
    step(); #1;
    n_cmp++; if ({bus_req, grant_i, grant_d, dmem_ready} !== 4'b0000) begin n_bad++; $display("FAIL rstmid_stale_grant: got %b want 0000", {bus_req, grant_i, grant_d, dmem_ready}); end
  endtask

  task automatic test_idle_noise();
    do_reset();
    bus_ready = 1; bus_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if ({bus_req, imem_ready, dmem_ready, grant_i, grant_d} !== 5'b0) begin n_bad++; $display("FAIL idle_noise[%0d]: got %b want 00000", k, {bus_req, imem_ready, dmem_ready, grant_i, grant_d}); end
      step();
    end
    bus_ready = 0;
  endtask

  task automatic test_random();
    logic [136:0] exp_v, got_v;
    bit done_i, done_d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus_ready = ($urandom_range(0, 2) != 0);
      bus_rdata = $urandom;
      done_i = (m_owner == 1) && bus_ready;
      done_d = (m_owner == 2) && bus_ready;
      if (!imem_req || done_i) begin
        imem_req  = ($urandom_range(0, 1) == 1);
        imem_addr = $urandom;
      end
      if (!dmem_req || done_d) begin
        dmem_req   = ($urandom_range(0, 2) != 0);
        dmem_addr  = $urandom;
        dmem_wdata = $urandom;
        dmem_we    = ($urandom_range(0, 1) == 1) ? 4'(($urandom)) : 4'h0;
      end
      exp_v = model_out();
      #1;
      got_v = {bus_req, bus_addr, bus_wdata, bus_we, imem_ready, dmem_ready,
               grant_i, grant_d, imem_rdata, dmem_rdata};
      n_cmp++; if (got_v !== exp_v) begin n_bad++; $display("FAIL random[%0d]: got %h want %h", c, got_v, exp_v); end
      @(posedge clk);
      model_tick();
      @(negedge clk);
    end
    imem_req = 0; dmem_req = 0; bus_ready = 0;
    step();
  endtask

  initial begin
    rst_n = 0;
    imem_req = 0; dmem_req = 0; bus_ready = 0;
    imem_addr = 0; dmem_addr = 0; dmem_wdata = 0; dmem_we = 0; bus_rdata = 0;
    @(negedge clk);
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_wait_states();
    test_starvation();
    test_reset_mid();
    test_idle_noise();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
